sha256_padder: RTL and testbench
================================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  input byte beat valid.
REQ-004 in_ready  out  1  padder accepts a beat this cycle; a transfer occurs when in_valid & in_ready.
REQ-005 in_data  in  8  message byte, first byte of message first.
REQ-006 in_keep  in  1  1 = in_data is a message byte; 0 = beat carries no byte.
REQ-007 in_last  in  1  final beat of the message.
REQ-008 block_valid  out  1  padded block available.
REQ-009 block_ready  in  1  hash core consumes the block; a transfer occurs when block_valid & block_ready.
REQ-010 block  out  512  padded block, bit-0-first ordering [0:511]; message byte n sits at block[8n +: 8].
REQ-011 block_last  out  1  with block_valid: final block of the message.

Function
REQ-012 The FSM SHALL have states ABSORB, PAD, LENBLK and EMIT; in_ready = 1 only in ABSORB.
REQ-013 ABSORB, kept byte accepted: buf[idx] <= in_data, idx (6 bit) += 1, bitlen (64 bit, wraps mod 2^64) += 8.
REQ-014 ABSORB, in_keep = 0 without in_last: the beat SHALL be consumed with no state change.
REQ-015 ABSORB, 64th byte of a block accepted (idx = 63) with in_last = 0 -> EMIT, final = 0, pad_pend = 0.
REQ-016 ABSORB, in_last accepted with the buffer not full after the write -> PAD.
REQ-017 ABSORB, in_last accepted with the buffer full after the write -> EMIT, final = 0, pad_pend = 1.
REQ-018 PAD (one cycle): buf[idx] <= 8'h80 and bytes idx+1..63 <= 0.
REQ-019 PAD, idx <= 55: bytes 56..63 <= bitlen, big-endian; final = 1.
REQ-020 PAD, idx >= 56: final = 0, len_pend = 1.
REQ-021 PAD always -> EMIT.
REQ-022 LENBLK (one cycle): bytes 0..55 <= 0, bytes 56..63 <= bitlen, final = 1; -> EMIT.
REQ-023 EMIT: block_valid = 1; block and block_last = final SHALL stay stable until the handshake.
REQ-024 EMIT handshake, final: -> ABSORB; idx, bitlen, pad_pend, len_pend cleared.
REQ-025 EMIT handshake, pad_pend: -> PAD with idx = 0 and the buffer cleared.
REQ-026 EMIT handshake, len_pend: -> LENBLK.
REQ-027 EMIT handshake, neither pend flag and not final: -> ABSORB with idx = 0; bitlen retained.
REQ-028 Latency: block_valid SHALL assert 1 cycle after the accepted 64th byte and 2 cycles after an accepted in_last (PAD, then EMIT).
REQ-029 Zero-length message (in_keep = 0, in_last = 1): one block = 0x80, zeros, length 0; block_last = 1.

Reset
REQ-030 Reset SHALL be synchronous, active-high, and override all other activity, including mid-message and EMIT.
REQ-031 Reset values: state = ABSORB, idx = 0, bitlen = 0, pend flags = 0, buf = 0, block_valid = 0, block_last = 0, in_ready = 1 from the first cycle after reset.

Configuration
REQ-032 With macro SHA256_PADDER_FIRST_EN defined, output block_first (1 bit) SHALL be provided.
REQ-033 block_first = 1 with block_valid for the first block of each message; reset value 0.
REQ-034 Without SHA256_PADDER_FIRST_EN, the port and its tracking flop SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package sha256_pkg SHALL hold: SHA256_BLOCK_W = 512, SHA256_LEN_W = 64, SHA256_PAD_BYTE = 8'h80, SHA256_LEN_OFS = 56, and the FSM state enum.
REQ-036 One combinational sub-module, sha256_pad_fill, SHALL build the PAD/LENBLK buffer image from (buf, idx, bitlen, mode).

Verification
REQ-037 "abc" (61 62 63, last) -> one block: 61626380, then zeros, last word 00000018; block_last = 1.
REQ-038 55 bytes -> one block: byte 55 = 80, length 0x1B8; block_last = 1.
REQ-039 56 bytes -> block 1: byte 56 = 80, block_last = 0; block 2: all zero except length 0x1C0, block_last = 1.
REQ-040 64 bytes -> block 1 = data, block_last = 0; block 2: byte 0 = 80, length 0x200, block_last = 1.
REQ-041 Empty message -> 80000000, zeros, length 0. Separately: hold block_ready = 0 for 10 cycles -> block stable, in_ready = 0 throughout.
REQ-042 Reset asserted mid-message after 20 bytes, then "abc" sent -> output identical to REQ-037.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 message padder: shared widths, constants and state encodings.
package sha256_pkg;

  localparam int unsigned SHA256_BLOCK_W  = 512;
  localparam int unsigned SHA256_LEN_W    = 64;
  localparam logic [7:0]  SHA256_PAD_BYTE = 8'h80;
  localparam int unsigned SHA256_LEN_OFS  = 56;
  localparam int unsigned SHA256_BYTES    = SHA256_BLOCK_W / 8;
  localparam int unsigned SHA256_IDX_W    = 6;

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    LENBLK,
    EMIT
  } sha256_state_e;

  // Which buffer image the fill network should produce.
  typedef enum logic {
    FILL_PAD,
    FILL_LEN
  } sha256_fill_e;

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational builder of the padded buffer image: either the 0x80 marker
// plus zero fill (with length when it fits) or a pure length block.
module sha256_pad_fill
  import sha256_pkg::*;
(
  input  logic [0:SHA256_BLOCK_W-1] i_buf,
  input  logic [SHA256_IDX_W-1:0]   i_idx,
  input  logic [SHA256_LEN_W-1:0]   i_bitlen,
  input  sha256_fill_e              i_mode,
  output logic [0:SHA256_BLOCK_W-1] o_img_c,
  output logic                      o_final_c
);

  // Build the image; bytes before idx keep their message content.
  always_comb begin
    o_img_c   = i_buf;
    o_final_c = 1'b1;
    if (i_mode == FILL_LEN) begin
      o_img_c = '0;
      o_img_c[SHA256_LEN_OFS*8 +: SHA256_LEN_W] = i_bitlen;
    end else begin
      for (int b = 0; b < SHA256_BYTES; b++) begin
        if (SHA256_IDX_W'(b) == i_idx) begin
          o_img_c[8*b +: 8] = SHA256_PAD_BYTE;
        end else if (SHA256_IDX_W'(b) > i_idx) begin
          o_img_c[8*b +: 8] = 8'h00;
        end
      end
      if (i_idx < SHA256_IDX_W'(SHA256_LEN_OFS)) begin
        o_img_c[SHA256_LEN_OFS*8 +: SHA256_LEN_W] = i_bitlen;
      end else begin
        o_final_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 byte-stream padder: absorbs message bytes into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
// Optional feature macro: SHA256_PADDER_FIRST_EN adds output block_first.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_keep,
  input  logic                      in_last,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic [0:SHA256_BLOCK_W-1] block,
  output logic                      block_last
`ifdef SHA256_PADDER_FIRST_EN
  ,
  output logic                      block_first
`endif
);

  sha256_state_e               r_state;
  logic [SHA256_IDX_W-1:0]     r_idx;
  logic [SHA256_LEN_W-1:0]     r_bitlen;
  logic [0:SHA256_BLOCK_W-1]   r_buf;
  logic                        r_final;
  logic                        r_pad_pend;
  logic                        r_len_pend;
  logic                        r_in_ready;
  logic                        r_block_valid;

  logic                        w_accept;
  logic                        w_take;
  logic                        w_full_byte;
  sha256_fill_e                w_mode;
  logic [0:SHA256_BLOCK_W-1]   w_fill_img;
  logic                        w_fill_final;

  assign w_accept    = in_valid & r_in_ready;
  assign w_take      = r_block_valid & block_ready;
  assign w_full_byte = w_accept & in_keep & (r_idx == SHA256_IDX_W'(SHA256_BYTES - 1));
  assign w_mode      = (r_state == LENBLK) ? FILL_LEN : FILL_PAD;

  sha256_pad_fill u_fill (
    .i_buf     (r_buf),
    .i_idx     (r_idx),
    .i_bitlen  (r_bitlen),
    .i_mode    (w_mode),
    .o_img_c   (w_fill_img),
    .o_final_c (w_fill_final)
  );

  // Main FSM: absorb bytes, pad, optional length block, hold block until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ABSORB;
      r_idx         <= '0;
      r_bitlen      <= '0;
      r_buf         <= '0;
      r_final       <= 1'b0;
      r_pad_pend    <= 1'b0;
      r_len_pend    <= 1'b0;
      r_in_ready    <= 1'b1;
      r_block_valid <= 1'b0;
    end else begin
      case (r_state)
        ABSORB: begin
          if (w_accept) begin
            if (in_keep) begin
              r_buf[{r_idx, 3'b000} +: 8] <= in_data;
              r_idx    <= r_idx + SHA256_IDX_W'(1);
              r_bitlen <= r_bitlen + SHA256_LEN_W'(8);
            end
            if (w_full_byte) begin
              r_state       <= EMIT;
              r_in_ready    <= 1'b0;
              r_block_valid <= 1'b1;
              r_final       <= 1'b0;
              r_pad_pend    <= in_last;
            end else if (in_last) begin
              r_state    <= PAD;
              r_in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          r_buf         <= w_fill_img;
          r_final       <= w_fill_final;
          r_len_pend    <= ~w_fill_final;
          r_pad_pend    <= 1'b0;
          r_state       <= EMIT;
          r_block_valid <= 1'b1;
        end
        LENBLK: begin
          r_buf         <= w_fill_img;
          r_final       <= 1'b1;
          r_len_pend    <= 1'b0;
          r_state       <= EMIT;
          r_block_valid <= 1'b1;
        end
        EMIT: begin
          if (w_take) begin
            r_block_valid <= 1'b0;
            if (r_final) begin
              r_state    <= ABSORB;
              r_in_ready <= 1'b1;
              r_idx      <= '0;
              r_bitlen   <= '0;
              r_pad_pend <= 1'b0;
              r_len_pend <= 1'b0;
              r_final    <= 1'b0;
            end else if (r_pad_pend) begin
              r_state <= PAD;
              r_idx   <= '0;
              r_buf   <= '0;
            end else if (r_len_pend) begin
              r_state <= LENBLK;
            end else begin
              r_state    <= ABSORB;
              r_in_ready <= 1'b1;
              r_idx      <= '0;
            end
          end
        end
        default: begin
          r_state <= ABSORB;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign block_valid = r_block_valid;
  assign block       = r_buf;
  assign block_last  = r_final;

`ifdef SHA256_PADDER_FIRST_EN
  logic r_first;
  logic r_more;

  // Flag the first block of each message; r_more marks blocks already sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first <= 1'b0;
      r_more  <= 1'b0;
    end else if (w_full_byte || (r_state == PAD) || (r_state == LENBLK)) begin
      r_first <= ~r_more;
    end else if ((r_state == EMIT) && w_take) begin
      r_first <= 1'b0;
      r_more  <= ~r_final;
    end
  end

  assign block_first = r_first;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder with a queue-based padding model.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_keep;
  logic         in_last;
  logic         block_valid;
  logic         block_ready;
  logic [0:511] block;
  logic         block_last;
`ifdef SHA256_PADDER_FIRST_EN
  logic         block_first;
`endif

  typedef struct {
    logic [0:511] data;
    logic         last;
    logic         first;
  } blk_t;

  blk_t got[$];
  blk_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ready_mode = 1;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_keep     (in_keep),
    .in_last     (in_last),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block       (block),
    .block_last  (block_last)
`ifdef SHA256_PADDER_FIRST_EN
    ,
    .block_first (block_first)
`endif
  );

  // Sink ready: 0 = hold off, 1 = always, otherwise random.
  initial begin
    block_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       block_ready = 1'b0;
        1:       block_ready = 1'b1;
        default: block_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Record every block handshake seen by the sink.
  always @(negedge clk) begin : mon
    blk_t b;
    if (!reset && block_valid && block_ready) begin
      b.data = block;
      b.last = block_last;
`ifdef SHA256_PADDER_FIRST_EN
      b.first = block_first;
`else
      b.first = 1'b0;
`endif
      got.push_back(b);
    end
  end

  // Standard SHA-256 padding of a whole message, split into 64-byte blocks.
  function automatic void model(input logic [7:0] msg[$]);
    logic [7:0]  p[$];
    logic [63:0] bl;
    blk_t        b;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) b.data[8*j +: 8] = p[64*k + j];
      b.last  = (k == nb - 1);
      b.first = (k == 0);
      exp_q.push_back(b);
    end
  endfunction

  task automatic beat(input logic [7:0] d, input logic k, input logic l, output bit ok);
    bit rdy;
    int n;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    rdy = 1'b0; n = 0;
    while (!rdy && n < 3000) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    ok = rdy;
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit gaps, output bit ok);
    bit b;
    bit sep;
    ok = 1'b1;
    sep = gaps && (msg.size() > 0) && ($urandom_range(0, 2) == 0);
    if (msg.size() == 0) begin
      beat(8'($urandom), 1'b0, 1'b1, b); ok &= b;
    end else begin
      for (int i = 0; i < msg.size(); i++) begin
        if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        if (gaps && $urandom_range(0, 5) == 0) begin beat(8'($urandom), 1'b0, 1'b0, b); ok &= b; end
        beat(msg[i], 1'b1, (i == msg.size() - 1) && !sep, b); ok &= b;
      end
      if (sep) begin beat(8'($urandom), 1'b0, 1'b1, b); ok &= b; end
    end
  endtask

  task automatic wait_blocks(input int n, output bit ok);
    int c = 0;
    while (got.size() < n && c < 5000) begin @(posedge clk); #1; c++; end
    repeat (3) begin @(posedge clk); #1; end
    ok = (got.size() == n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (block_valid !== 1'b0) begin n_err++; $display("FAIL reset_block_valid got=%b want=0", block_valid); end
    n_cmp++; if (block_last !== 1'b0) begin n_err++; $display("FAIL reset_block_last got=%b want=0", block_last); end
    n_cmp++; if (block !== 512'h0) begin n_err++; $display("FAIL reset_block got=%h want=0", block); end
`ifdef SHA256_PADDER_FIRST_EN
    n_cmp++; if (block_first !== 1'b0) begin n_err++; $display("FAIL reset_block_first got=%b want=0", block_first); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int           lens[5] = '{3, 55, 56, 64, 0};
    logic [7:0]   msg[$];
    logic [0:511] g0, g1;
    bit           ok;
    ready_mode = 1;
    for (int v = 0; v < 5; v++) begin
      msg.delete();
      if (v == 0) begin msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63); end
      else for (int i = 0; i < lens[v]; i++) msg.push_back(8'($urandom));
      got.delete(); exp_q.delete(); model(msg);
      send_msg(msg, 1'b0, ok);
      if (ok) wait_blocks(exp_q.size(), ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL vec%0d_count got=%0d want=%0d", v, got.size(), exp_q.size()); continue; end
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (got[k].data !== exp_q[k].data || got[k].last !== exp_q[k].last) begin
          n_err++; $display("FAIL vec%0d_blk%0d got=%h/%b want=%h/%b", v, k, got[k].data, got[k].last, exp_q[k].data, exp_q[k].last);
        end
`ifdef SHA256_PADDER_FIRST_EN
        n_cmp++;
        if (got[k].first !== exp_q[k].first) begin n_err++; $display("FAIL vec%0d_first%0d got=%b want=%b", v, k, got[k].first, exp_q[k].first); end
`endif
      end
      g0 = got[0].data;
      g1 = (got.size() > 1) ? got[1].data : 512'h0;
      case (v)
        0: begin
          n_cmp++; if (g0[0:31] !== 32'h61626380 || g0[32:479] !== 448'h0 || g0[480:511] !== 32'h18 || got[0].last !== 1'b1) begin
            n_err++; $display("FAIL abc_block got=%h last=%b", g0, got[0].last); end
        end
        1: begin
          n_cmp++; if (g0[440:447] !== 8'h80 || g0[448:511] !== 64'h1B8 || got[0].last !== 1'b1) begin
            n_err++; $display("FAIL len55 got=%h last=%b want byte55=80 len=1b8", g0, got[0].last); end
        end
        2: begin
          n_cmp++; if (g0[448:455] !== 8'h80 || g0[456:511] !== 56'h0 || got[0].last !== 1'b0) begin
            n_err++; $display("FAIL len56_b1 got=%h last=%b", g0, got[0].last); end
          n_cmp++; if (g1 !== {448'h0, 64'h1C0} || got[1].last !== 1'b1) begin
            n_err++; $display("FAIL len56_b2 got=%h last=%b", g1, got[1].last); end
        end
        3: begin
          n_cmp++; if (got[0].last !== 1'b0 || g1[0:7] !== 8'h80 || g1[8:447] !== 440'h0 || g1[448:511] !== 64'h200 || got[1].last !== 1'b1) begin
            n_err++; $display("FAIL len64 got=%h last=%b/%b", g1, got[0].last, got[1].last); end
        end
        default: begin
          n_cmp++; if (g0 !== {8'h80, 504'h0} || got[0].last !== 1'b1) begin
            n_err++; $display("FAIL empty got=%h last=%b", g0, got[0].last); end
        end
      endcase
    end
  endtask

  task automatic test_latency();
    logic [7:0] msg[$];
    bit         ok;
    ready_mode = 0;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b0, ok);
    @(negedge clk);
    n_cmp++; if (!ok || block_valid !== 1'b0) begin n_err++; $display("FAIL lat_last_pad got=%b want=0", block_valid); end
    @(negedge clk);
    n_cmp++; if (block_valid !== 1'b1) begin n_err++; $display("FAIL lat_last_emit got=%b want=1", block_valid); end
    got.delete(); ready_mode = 1;
    repeat (4) @(posedge clk); #1;
    ready_mode = 0;
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    send_msg(msg, 1'b0, ok);
    @(negedge clk);
    n_cmp++; if (!ok || block_valid !== 1'b1) begin n_err++; $display("FAIL lat_full got=%b want=1", block_valid); end
    got.delete(); exp_q.delete(); model(msg);
    ready_mode = 1;
    wait_blocks(2, ok);
    n_cmp++; if (!ok || got[0].data !== exp_q[0].data || got[1].data !== exp_q[1].data) begin
      n_err++; $display("FAIL lat_full_data got_n=%0d want_n=2", got.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0]   msg[$];
    logic [0:511] h;
    bit           ok;
    int           c = 0;
    ready_mode = 0;
    msg.delete();
    send_msg(msg, 1'b0, ok);
    while (!block_valid && c < 100) begin @(negedge clk); c++; end
    h = block;
    n_cmp++; if (h !== {8'h80, 504'h0}) begin n_err++; $display("FAIL bp_block got=%h want=80..0", h); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (block !== h || block_valid !== 1'b1 || in_ready !== 1'b0 || block_last !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d got=%h v=%b r=%b l=%b", i, block, block_valid, in_ready, block_last);
      end
    end
    got.delete(); ready_mode = 1;
    wait_blocks(1, ok);
    n_cmp++; if (!ok || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release n=%0d in_ready=%b", got.size(), in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] msg[$];
    bit         ok;
    bit         b;
    ready_mode = 1;
    for (int i = 0; i < 20; i++) begin beat(8'($urandom), 1'b1, 1'b0, b); end
    do_reset();
    got.delete(); exp_q.delete();
    msg = '{8'h61, 8'h62, 8'h63};
    model(msg);
    send_msg(msg, 1'b0, ok);
    if (ok) wait_blocks(1, ok);
    n_cmp++;
    if (!ok || got[0].data !== exp_q[0].data || got[0].last !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_abc n=%0d want=1 block", got.size());
    end
    ready_mode = 0;
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    send_msg(msg, 1'b0, ok);
    repeat (3) begin @(posedge clk); #1; end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1 || block !== 512'h0) begin
      n_err++; $display("FAIL rst_emit v=%b r=%b want v=0 r=1 block=0", block_valid, in_ready);
    end
    ready_mode = 1;
    got.delete();
  endtask

  task automatic test_random();
    logic [7:0] msg[$];
    bit         ok;
    int         len;
    ready_mode = 2;
    for (int m = 0; m < 14; m++) begin
      len = $urandom_range(0, 140);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      got.delete(); exp_q.delete(); model(msg);
      send_msg(msg, 1'b1, ok);
      if (ok) wait_blocks(exp_q.size(), ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rnd%0d_count len=%0d got=%0d want=%0d", m, len, got.size(), exp_q.size()); continue; end
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (got[k].data !== exp_q[k].data || got[k].last !== exp_q[k].last) begin
          n_err++; $display("FAIL rnd%0d_blk%0d len=%0d got=%h/%b want=%h/%b", m, k, len, got[k].data, got[k].last, exp_q[k].data, exp_q[k].last);
        end
`ifdef SHA256_PADDER_FIRST_EN
        n_cmp++;
        if (got[k].first !== exp_q[k].first) begin n_err++; $display("FAIL rnd%0d_first%0d got=%b want=%b", m, k, got[k].first, exp_q[k].first); end
`endif
      end
    end
    ready_mode = 1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
